// File: rtl/frame_sync.sv
// Frame synchroniser: sliding-window Barker search, one-frame verify, flywheel lock
// with polarity correction of the payload bits.
module frame_sync #(
    parameter logic [6:0] BARKER    = 7'b1110010,
    parameter int         FRAME_LEN = 57,
    parameter int         THRESH    = 6,
    parameter int         MISS_MAX  = 2
) (
    input  logic div_5_clk_sig,
    input  logic rst_n,
    input  logic bit_in,
    input  logic bit_vld,
    output logic data_out,
    output logic data_vld,
    output logic frame_start,
    output logic locked,
    output logic polarity
);

    localparam int          MW         = $clog2(MISS_MAX + 1);
    localparam logic [5:0]  POS_LAST   = 6'(FRAME_LEN - 1);
    localparam logic [5:0]  PAY_LAST   = 6'(FRAME_LEN - 8);
    localparam logic [2:0]  THRESH_C   = 3'(THRESH);
    localparam logic [MW-1:0] MISS_LIMIT = MW'(MISS_MAX);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    function automatic logic [2:0] popcount7(input logic [6:0] v);
        logic [2:0] cnt;
        cnt = 3'd0;
        for (int i = 0; i < 7; i++) begin
            cnt = cnt + {2'b00, v[i]};
        end
        return cnt;
    endfunction

    state_t        state_r, state_next_s;
    logic [5:0]    sr_r;
    logic [6:0]    sr_next_s;
    logic [2:0]    fill_r;
    logic [5:0]    pos_r, pos_next_s;
    logic [MW-1:0] miss_cnt_r, miss_next_s, miss_inc_s;
    logic          polarity_r, pol_next_s;
    logic          data_out_r, data_vld_r, frame_start_r, locked_r;
    logic          full_s, hit_p_s, hit_n_s, match_s, boundary_s, payload_s, fs_next_s;

    // Only six history bits are stored; the seventh window bit is the live input.
    assign sr_next_s  = {sr_r, bit_in};
    assign full_s     = (fill_r >= 3'd6);
    assign hit_p_s    = full_s && (popcount7(~(sr_next_s ^ BARKER)) >= THRESH_C);
    assign hit_n_s    = full_s && (popcount7(sr_next_s ^ BARKER) >= THRESH_C);
    assign match_s    = polarity_r ? hit_n_s : hit_p_s;
    assign boundary_s = (pos_r == POS_LAST);
    assign payload_s  = (state_r == LOCKED) && (pos_r <= PAY_LAST);
    assign miss_inc_s = miss_cnt_r + MW'(1);

    // Next-state, frame position, miss counter, polarity and frame_start decision.
    always_comb begin
        state_next_s = state_r;
        pos_next_s   = boundary_s ? 6'd0 : pos_r + 6'd1;
        miss_next_s  = miss_cnt_r;
        pol_next_s   = polarity_r;
        fs_next_s    = 1'b0;
        case (state_r)
            SEARCH: begin
                if (hit_p_s || hit_n_s) begin
                    state_next_s = VERIFY;
                    pos_next_s   = 6'd0;
                    pol_next_s   = ~hit_p_s;
                end else begin
                    state_next_s = SEARCH;
                end
            end
            VERIFY: begin
                if (boundary_s && match_s) begin
                    state_next_s = LOCKED;
                    fs_next_s    = 1'b1;
                end else if (boundary_s) begin
                    state_next_s = SEARCH;
                end else begin
                    state_next_s = VERIFY;
                end
            end
            LOCKED: begin
                if (boundary_s && match_s) begin
                    miss_next_s = {MW{1'b0}};
                    fs_next_s   = 1'b1;
                end else if (boundary_s && (miss_inc_s == MISS_LIMIT)) begin
                    state_next_s = SEARCH;
                    miss_next_s  = {MW{1'b0}};
                end else if (boundary_s) begin
                    miss_next_s = miss_inc_s;
                    fs_next_s   = 1'b1;
                end else begin
                    state_next_s = LOCKED;
                end
            end
            default: begin
                state_next_s = SEARCH;
                miss_next_s  = {MW{1'b0}};
            end
        endcase
    end

    // State and datapath registers; everything advances only on valid bits.
    always_ff @(posedge div_5_clk_sig) begin
        if (!rst_n) begin
            state_r       <= SEARCH;
            sr_r          <= 6'd0;
            fill_r        <= 3'd0;
            pos_r         <= 6'd0;
            miss_cnt_r    <= {MW{1'b0}};
            polarity_r    <= 1'b0;
            data_out_r    <= 1'b0;
            data_vld_r    <= 1'b0;
            frame_start_r <= 1'b0;
            locked_r      <= 1'b0;
        end else if (bit_vld) begin
            state_r       <= state_next_s;
            sr_r          <= sr_next_s[5:0];
            fill_r        <= (fill_r == 3'd7) ? 3'd7 : fill_r + 3'd1;
            pos_r         <= pos_next_s;
            miss_cnt_r    <= miss_next_s;
            polarity_r    <= pol_next_s;
            data_out_r    <= payload_s ? (bit_in ^ polarity_r) : data_out_r;
            data_vld_r    <= payload_s;
            frame_start_r <= fs_next_s;
            locked_r      <= (state_next_s == LOCKED);
        end else begin
            data_vld_r    <= 1'b0;
            frame_start_r <= 1'b0;
        end
    end

    assign data_out    = data_out_r;
    assign data_vld    = data_vld_r;
    assign frame_start = frame_start_r;
    assign locked      = locked_r;
    assign polarity    = polarity_r;

endmodule

// File: tb/tb_frame_sync.sv
// Self-checking bench for frame_sync: scenario table, hand sequences and random
// streams, all checked cycle by cycle against a frame-offset reference model.
module tb_frame_sync;

    localparam logic [6:0] BARKER_W = 7'b1110010;
    localparam int         FLEN     = 57;

    logic div_5_clk_sig = 1'b0;
    logic rst_n = 1'b0, bit_in = 1'b0, bit_vld = 1'b0;
    logic data_out, data_vld, frame_start, locked, polarity;

    int tests = 0;
    int fails = 0;

    frame_sync dut (
        .div_5_clk_sig(div_5_clk_sig), .rst_n(rst_n), .bit_in(bit_in), .bit_vld(bit_vld),
        .data_out(data_out), .data_vld(data_vld), .frame_start(frame_start),
        .locked(locked), .polarity(polarity)
    );

    always #5 div_5_clk_sig = ~div_5_clk_sig;

    // Reference model: bit history since reset, index of the accepted sync bit,
    // mode 0 search / 1 verify / 2 locked.
    bit m_hist[$];
    int m_n, m_anchor, m_mode, m_miss;
    bit m_pol;
    bit e_dv, e_do, e_fs, e_lk;

    task automatic model_step(input bit r, input bit v, input bit b);
        int n, score, pos;
        bit hp, hn, good;
        if (!r) begin
            m_hist.delete(); m_n = 0; m_anchor = 0; m_mode = 0; m_miss = 0; m_pol = 1'b0;
            e_dv = 1'b0; e_do = 1'b0; e_fs = 1'b0; e_lk = 1'b0;
        end else if (!v) begin
            e_dv = 1'b0; e_fs = 1'b0;
        end else begin
            m_hist.push_back(b);
            n = m_n;
            m_n++;
            score = 0;
            if (n >= 6) begin
                for (int k = 0; k < 7; k++) begin
                    if (m_hist[n - 6 + k] == BARKER_W[6 - k]) score++;
                end
            end
            hp = (n >= 6) && (score >= 6);
            hn = (n >= 6) && ((7 - score) >= 6);
            good = m_pol ? hn : hp;
            pos = (m_mode != 0) ? (n - m_anchor - 1) % FLEN : 0;
            e_dv = 1'b0; e_fs = 1'b0;
            if (m_mode == 0) begin
                if (hp || hn) begin
                    m_mode = 1; m_anchor = n; m_pol = !hp;
                end
            end else if (m_mode == 1) begin
                if (pos == FLEN - 1) begin
                    if (good) begin m_mode = 2; e_fs = 1'b1; end
                    else m_mode = 0;
                end
            end else begin
                if (pos <= FLEN - 8) begin e_dv = 1'b1; e_do = b ^ m_pol; end
                if (pos == FLEN - 1) begin
                    if (good) begin m_miss = 0; e_fs = 1'b1; end
                    else begin
                        m_miss++;
                        if (m_miss == 2) begin m_mode = 0; m_miss = 0; end
                        else e_fs = 1'b1;
                    end
                end
            end
            e_lk = (m_mode == 2);
        end
    endtask

    // Observation state for the current run.
    int  vidx, dv_cnt, fs_cnt, rise_idx, fall_idx;
    bit  prev_lk;
    bit  got_q[$];
    bit  stream_q[$];
    bit  exp_pay_q[$];

    task automatic check_int(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic step(input bit r, input bit v, input bit b);
        @(negedge div_5_clk_sig);
        rst_n = r; bit_vld = v; bit_in = b;
        @(posedge div_5_clk_sig);
        #1;
        model_step(r, v, b);
        tests++;
        if ({data_vld, frame_start, locked, polarity} !== {e_dv, e_fs, e_lk, m_pol} ||
            (e_dv && (data_out !== e_do))) begin
            fails++;
            $display("FAIL cycle t=%0t: dv/fs/lk/pol/do got %b%b%b%b%b expected %b%b%b%b%b",
                     $time, data_vld, frame_start, locked, polarity, data_out,
                     e_dv, e_fs, e_lk, m_pol, e_do);
        end
        if (r && v) vidx++;
        if (data_vld) begin dv_cnt++; got_q.push_back(data_out); end
        if (frame_start) fs_cnt++;
        if (locked && !prev_lk && rise_idx < 0) rise_idx = vidx - 1;
        if (!locked && prev_lk && fall_idx < 0) fall_idx = vidx - 1;
        prev_lk = locked;
    endtask

    task automatic do_reset(input int cycles);
        repeat (cycles) step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        vidx = 0; dv_cnt = 0; fs_cnt = 0; rise_idx = -1; fall_idx = -1;
        prev_lk = 1'b0; got_q.delete();
    endtask

    // Appends frames (sync then 50 payload bits); exp_pay_q gets frames 2 and 3.
    task automatic build_frames(input int nfr, input bit inv, input logic [6:0] fl3,
                                input logic [6:0] fl4, input bit rnd_flips);
        logic [6:0] s, mask;
        bit pb;
        for (int f = 0; f < nfr; f++) begin
            mask = (f == 2) ? fl3 : ((f == 3) ? fl4 : 7'd0);
            if (rnd_flips) begin
                mask = 7'd0;
                repeat ($urandom_range(0, 2)) mask[$urandom_range(0, 6)] = 1'b1;
            end
            s = BARKER_W ^ mask;
            for (int k = 6; k >= 0; k--) stream_q.push_back(s[k] ^ inv);
            for (int p = 0; p < 50; p++) begin
                pb = 1'($urandom_range(0, 1));
                stream_q.push_back(pb ^ inv);
                if (f == 1 || f == 2) exp_pay_q.push_back(pb);
            end
        end
    endtask

    task automatic build_false_start();
        bit pre[40];
        logic [9:0] fixed;
        logic [6:0] bad;
        int sc, tries;
        bit ok;
        fixed = 10'b0001110010;
        tries = 0;
        do begin
            for (int i = 0; i < 30; i++) pre[i] = 1'($urandom_range(0, 1));
            for (int i = 0; i < 10; i++) pre[30 + i] = fixed[9 - i];
            ok = 1'b1;
            for (int e = 6; e <= 38; e++) begin
                sc = 0;
                for (int k = 0; k < 7; k++) if (pre[e - 6 + k] == BARKER_W[6 - k]) sc++;
                if (sc >= 6 || sc <= 1) ok = 1'b0;
            end
            tries++;
        end while (!ok && tries < 1000);
        for (int i = 0; i < 40; i++) stream_q.push_back(pre[i]);
        for (int i = 0; i < 50; i++) stream_q.push_back(1'($urandom_range(0, 1)));
        bad = BARKER_W ^ 7'b0000111;
        for (int k = 6; k >= 0; k--) stream_q.push_back(bad[k]);
    endtask

    task automatic run_stream(input bit gaps, input int limit);
        int n;
        n = (limit < stream_q.size()) ? limit : stream_q.size();
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, 4)) step(1'b1, 1'b0, 1'($urandom_range(0, 1)));
            step(1'b1, 1'b1, stream_q[i]);
        end
        repeat (3) step(1'b1, 1'b0, 1'($urandom_range(0, 1)));
    endtask

    typedef struct packed {
        int         nframes;
        logic       inv;
        logic [6:0] fl3;
        logic [6:0] fl4;
        logic       gaps;
        logic       fstart;
        int         exp_fs;
        int         exp_dv;
        int         exp_pol;   // -1: not checked
        logic       exp_lk;
        int         exp_rise;
        int         exp_fall;
    } vec_t;

    initial begin
        vec_t vecs[6];
        int mism;
        vecs[0] = '{3, 1'b0, 7'd0, 7'd0, 1'b0, 1'b0, 2, 100, 0, 1'b1, 63, -1};
        vecs[1] = '{3, 1'b1, 7'd0, 7'd0, 1'b0, 1'b0, 2, 100, 1, 1'b1, 63, -1};
        vecs[2] = '{3, 1'b0, 7'b0000001, 7'd0, 1'b0, 1'b0, 2, 100, 0, 1'b1, 63, -1};
        vecs[3] = '{4, 1'b0, 7'b0000011, 7'b0000011, 1'b0, 1'b0, 2, 100, -1, 1'b0, 63, 177};
        vecs[4] = '{3, 1'b0, 7'd0, 7'd0, 1'b1, 1'b0, 2, 100, 0, 1'b1, 63, -1};
        vecs[5] = '{0, 1'b0, 7'd0, 7'd0, 1'b0, 1'b1, 0, 0, 0, 1'b0, -1, -1};

        // Reset with random inputs, then the first cycle after release.
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            check_int("reset_outputs", int'({data_out, data_vld, frame_start, locked, polarity}), 0);
        end
        step(1'b1, 1'b1, 1'($urandom_range(0, 1)));
        check_int("post_reset_outputs", int'({data_out, data_vld, frame_start, locked, polarity}), 0);

        for (int v = 0; v < 6; v++) begin
            do_reset(2);
            stream_q.delete(); exp_pay_q.delete();
            if (vecs[v].fstart) build_false_start();
            else build_frames(vecs[v].nframes, vecs[v].inv, vecs[v].fl3, vecs[v].fl4, 1'b0);
            run_stream(vecs[v].gaps, 100000);
            check_int($sformatf("v%0d_frame_start_count", v), fs_cnt, vecs[v].exp_fs);
            check_int($sformatf("v%0d_data_vld_count", v), dv_cnt, vecs[v].exp_dv);
            check_int($sformatf("v%0d_locked_end", v), int'(locked), int'(vecs[v].exp_lk));
            check_int($sformatf("v%0d_lock_rise_bit", v), rise_idx, vecs[v].exp_rise);
            check_int($sformatf("v%0d_lock_fall_bit", v), fall_idx, vecs[v].exp_fall);
            if (vecs[v].exp_pol >= 0)
                check_int($sformatf("v%0d_polarity", v), int'(polarity), vecs[v].exp_pol);
            if (vecs[v].exp_dv == 100) begin
                mism = (got_q.size() > exp_pay_q.size()) ? got_q.size() - exp_pay_q.size()
                                                          : exp_pay_q.size() - got_q.size();
                for (int i = 0; i < got_q.size() && i < exp_pay_q.size(); i++)
                    if (got_q[i] != exp_pay_q[i]) mism++;
                check_int($sformatf("v%0d_payload_mismatches", v), mism, 0);
            end
        end

        // Reset in the middle of a locked frame, then reacquire from scratch.
        do_reset(2);
        stream_q.delete(); exp_pay_q.delete();
        build_frames(3, 1'b0, 7'd0, 7'd0, 1'b0);
        run_stream(1'b0, 100);
        check_int("midframe_locked_before_reset", int'(locked), 1);
        do_reset(2);
        check_int("midframe_reset_outputs", int'({data_vld, frame_start, locked, polarity}), 0);
        stream_q.delete(); exp_pay_q.delete();
        build_frames(3, 1'b0, 7'd0, 7'd0, 1'b0);
        run_stream(1'b0, 100000);
        check_int("reacquire_rise_bit", rise_idx, 63);
        check_int("reacquire_data_vld_count", dv_cnt, 100);

        // Random streams: junk prefix, random frame count, inversion, sync errors, gaps.
        for (int r = 0; r < 15; r++) begin
            do_reset($urandom_range(1, 3));
            stream_q.delete(); exp_pay_q.delete();
            repeat ($urandom_range(0, 30)) stream_q.push_back(1'($urandom_range(0, 1)));
            build_frames($urandom_range(2, 5), 1'($urandom_range(0, 1)), 7'd0, 7'd0, 1'b1);
            run_stream(1'($urandom_range(0, 1)), 100000);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/frame_sync.md
FRAME_SYNC -- requirements
Module: frame_sync

Interface
REQ-001 Parameter BARKER, 7'b1110010, sync word; bit 6 is received first.
REQ-002 Parameter FRAME_LEN, 57, bits per frame: 7 sync + 50 payload.
REQ-003 Parameter THRESH, 6, minimum bit matches out of 7 that count as a sync hit.
REQ-004 Parameter MISS_MAX, 2, consecutive missed syncs in LOCKED that force SEARCH.
REQ-005 Port div_5_clk_sig, input, 1, clock; all state on its rising edge.
REQ-006 Port rst_n, input, 1, reset, synchronous, active-low.
REQ-007 Port bit_in, input, 1, hard-decision demodulated bit.
REQ-008 Port bit_vld, input, 1, bit_in is valid this cycle.
REQ-009 Port data_out, output, 1, polarity-corrected payload bit.
REQ-010 Port data_vld, output, 1, data_out valid for one cycle.
REQ-011 Port frame_start, output, 1, one-cycle pulse on each accepted sync boundary.
REQ-012 Port locked, output, 1, high while in LOCKED.
REQ-013 Port polarity, output, 1, 1 = inverted carrier phase detected.

Function
REQ-014 All state SHALL advance only on cycles with bit_vld=1; when bit_vld=0 all state holds and data_vld/frame_start are 0.
REQ-015 Shift register: sr_next = {sr[5:0], bit_in}, register sr <= sr_next.
REQ-016 Fill counter (0..7, saturating) SHALL gate hits, so no hit is possible until 7 valid bits have been received.
REQ-017 Match counting: hit_p when popcount(~(sr_next ^ BARKER)) >= THRESH; hit_n when popcount(sr_next ^ BARKER) >= THRESH; both are combinational on sr_next.
REQ-018 Position counter pos, 6 bits: pos <= (pos==FRAME_LEN-1) ? 0 : pos+1 on each valid bit. The boundary bit is the valid bit where pos==FRAME_LEN-1.
REQ-019 States SHALL be SEARCH, VERIFY and LOCKED, binary-encoded.
REQ-020 SEARCH: on hit_p or hit_n, go to VERIFY, set pos <= 0, set polarity <= hit_n; hit_p wins if both fire; otherwise stay.
REQ-021 VERIFY, boundary bit: if the hit matches stored polarity (hit_p for polarity 0, hit_n for 1), go to LOCKED and pulse frame_start; otherwise go to SEARCH.
REQ-022 LOCKED, boundary bit with matching hit: clear miss_cnt and pulse frame_start.
REQ-023 LOCKED, boundary bit without matching hit: increment miss_cnt; if miss_cnt+1 == MISS_MAX, go to SEARCH with miss_cnt <= 0; else stay and still pulse frame_start (flywheel).
REQ-024 Payload: in LOCKED, a valid bit with pos in 0..FRAME_LEN-8 (0..49) is payload; data_out <= bit_in ^ polarity, data_vld <= 1, one cycle after the input cycle.
REQ-025 Bits with pos in 50..56, and all bits in SEARCH or VERIFY, SHALL produce data_vld=0.
REQ-026 frame_start and locked SHALL be registered; both update in the cycle after the boundary bit.
REQ-027 The first payload bit after VERIFY->LOCKED SHALL be the first valid bit following the boundary bit.
REQ-028 A wrong-polarity hit in VERIFY or LOCKED SHALL count as a miss.
REQ-029 Sync is sliding-window in SEARCH only; hits at non-boundary positions in VERIFY or LOCKED SHALL be ignored.

Reset
REQ-030 While rst_n=0 at a clock edge: state <= SEARCH; sr, fill, pos, miss_cnt <= 0; data_out, data_vld, frame_start, locked, polarity <= 0.
REQ-031 Reset mid-frame SHALL abandon the frame; acquisition restarts from SEARCH with an empty fill counter.

Verification
REQ-032 Reset: hold rst_n=0 for 3 cycles with random bit_in/bit_vld -> all outputs 0 throughout and the cycle after release.
REQ-033 Clean lock: 3 frames of 1110010 + 50-bit pattern, bit_vld=1 -> locked rises 1 cycle after the 2nd sync's last bit; frame_start pulses twice; exactly 100 data_vld pulses equal to the frame 2 and 3 payloads.
REQ-034 Inverted stream: same frames bit-inverted -> polarity=1, locked as in REQ-033, data_out equals the original (non-inverted) payload.
REQ-035 Errors: 1 flipped sync bit in frame 3 -> stays locked; 2 flipped bits in frames 3 and 4 -> locked stays high after frame 3 and drops 1 cycle after frame 4's boundary bit.
REQ-036 Gaps: REQ-033 stream with bit_vld=0 inserted randomly (up to 4 cycles) -> identical data_out sequence and frame_start count.
REQ-037 False start: random 30 bits, then 0001110010 followed by a corrupted boundary -> VERIFY then back to SEARCH, no data_vld, locked stays 0.
